// File: rtl/filter_burst_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : filter_burst_ctrl_if
//  Description : Bundle of the sample-source handshake, filter-core drive and
//                captured-output signals around filter_burst_ctrl.
//                master : the controller's view (drives filter + outputs)
//                slave  : the environment's view (source, filter core, sink)
//  Signals     : start, burst_len, in_data, in_valid, in_ready, flt_clr,
//                flt_en, flt_x, flt_y, out_data, out_valid, out_last,
//                busy, done
//  Revision    : 1.0  initial release
// ============================================================================
interface filter_burst_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flt_clr;
    logic                  flt_en;
    logic [DATA_WIDTH-1:0] flt_x;
    logic [DATA_WIDTH-1:0] flt_y;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, burst_len, in_data, in_valid, flt_y,
        output in_ready, flt_clr, flt_en, flt_x,
               out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output start, burst_len, in_data, in_valid, flt_y,
        input  in_ready, flt_clr, flt_en, flt_x,
               out_data, out_valid, out_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/filter_burst_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : filter_burst_ctrl
//  Description : Sequences one burst of samples through a shared FIR filter:
//                clear the delay line, stream burst_len source samples in
//                over valid/ready, inject FLUSH_LEN zeros to drain the taps,
//                and tag every filter output with valid/last.
//  Ports       : CLK        - clock, rising edge
//                RST        - asynchronous active-high reset
//                bus        - filter_burst_ctrl_if.master (source handshake,
//                             filter drive, captured output, busy/done)
//  Revision    : 1.0  initial release
// ============================================================================
module filter_burst_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int LATENCY    = 1,
    parameter int FLUSH_LEN  = 3
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    filter_burst_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [3:0]         c_FLUSH_LAST = 4'(FLUSH_LEN - 1);
    // Every pipeline stage except the output stage. When these are empty the
    // entry now leaving the register is the last one of the burst.
    localparam logic [LATENCY-1:0] c_PEND_MASK  = {LATENCY{1'b1}} >> 1;

    state_t                r_state;
    state_t                w_next;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic [3:0]            r_fcnt;
    logic [DATA_WIDTH-1:0] r_x;
    logic [LATENCY-1:0]    r_pipe_v;
    logic [LATENCY-1:0]    r_pipe_last;

    logic                  w_accept;
    logic                  w_last_sample;
    logic                  w_flush_last;
    logic                  w_in_ready;
    logic                  w_clr;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_x;

    // Compare against len-1 rather than incrementing first so that a
    // full-scale length finishes without the counter wrapping.
    assign w_last_sample = (r_cnt == (r_len - LEN_WIDTH'(1)));
    assign w_flush_last  = (r_state == S_FLUSH) && (r_fcnt == c_FLUSH_LAST);

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_clr      = 1'b0;
        w_accept   = 1'b0;
        w_en       = 1'b0;
        w_x        = r_x;   // stalls keep presenting the last sample
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.burst_len != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                w_clr  = 1'b1;
                w_next = S_LOAD;
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_en     = 1'b1;
                    w_x      = bus.in_data;
                    if (w_last_sample) begin
                        w_next = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                w_en = 1'b1;
                w_x  = '0;
                if (w_flush_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_pipe_v & c_PEND_MASK) == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_fcnt      <= '0;
            r_x         <= '0;
            r_pipe_v    <= '0;
            r_pipe_last <= '0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) && bus.start && (bus.burst_len != '0)) begin
                r_len <= bus.burst_len;
            end

            if (r_state == S_CLEAR) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + LEN_WIDTH'(1);
            end

            if (r_state == S_FLUSH) begin
                r_fcnt <= r_fcnt + 4'd1;
            end else begin
                r_fcnt <= '0;
            end

            if (w_en) begin
                r_x <= w_x;
            end

            // Enable/last tags travel alongside the filter's own latency so
            // each tag lines up with the flt_y it qualifies.
            r_pipe_v[0]    <= w_en;
            r_pipe_last[0] <= w_flush_last;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.flt_clr   = w_clr;
    assign bus.flt_en    = w_en;
    assign bus.flt_x     = w_x;
    assign bus.out_valid = r_pipe_v[LATENCY-1];
    assign bus.out_last  = r_pipe_v[LATENCY-1] & r_pipe_last[LATENCY-1];
    assign bus.out_data  = r_pipe_v[LATENCY-1] ? bus.flt_y : '0;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_filter_burst_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_filter_burst_ctrl
//  Description : Self-checking bench for filter_burst_ctrl with a y = 2x
//                registered filter model and a queue-based output scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_filter_burst_ctrl;

    localparam int DW    = 8;
    localparam int LW    = 8;
    localparam int LAT   = 1;
    localparam int FLUSH = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        int          len;
        logic [31:0] vpat;      // bit c = in_valid offered on cycle c after start
        int          restart;   // cycle to re-pulse start (0 = never)
        int          exp_outs;
        int          exp_stall; // -1 = not checked
        bit          ramp;      // samples 1,2,3.. instead of random
    } vec_t;

    logic CLK;
    logic RST;
    int   cyc = 0;

    filter_burst_ctrl_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    filter_burst_ctrl #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .LATENCY   (LAT),
        .FLUSH_LEN (FLUSH)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Filter core model: y = 2x, registered, enable-gated, cleared by flt_clr.
    logic [DW-1:0] r_y = '0;
    always @(posedge CLK) begin
        if (bus.flt_clr)     r_y <= '0;
        else if (bus.flt_en) r_y <= 8'(bus.flt_x * 2);
    end
    assign bus.flt_y = r_y;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Scoreboard and observation counters
    exp_t          exp_q[$];
    logic [DW-1:0] en_log[$];
    exp_t          e;
    int            n_out = 0, done_cnt = 0, busy_cnt = 0, clr_cnt = 0, stall_cnt = 0;
    int            clr_cyc = 0, first_en_cyc = -1, last_en_cyc = 0;
    logic [DW-1:0] last_x = '0;
    bit            prev_last = 0;
    bit            exp_last_flag = 0;

    always @(negedge CLK) begin
        if (RST) begin
            exp_q.delete();
            prev_last = 0;
            last_x    = '0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.flt_clr) begin
                clr_cnt++;
                clr_cyc = cyc;
            end
            if (bus.in_ready && !bus.in_valid) begin
                stall_cnt++;
                check("stall_en_low", int'(bus.flt_en), 0);
                check("stall_x_hold", int'(bus.flt_x), int'(last_x));
            end
            if (bus.flt_en) begin
                en_log.push_back(bus.flt_x);
                if (first_en_cyc < 0) first_en_cyc = cyc;
                last_en_cyc = cyc;
                last_x      = bus.flt_x;
            end
            if (bus.out_valid) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", int'(bus.out_data), int'(e.data));
                    check("out_last", int'(bus.out_last), int'(e.last));
                end
            end
            if (bus.done) begin
                done_cnt++;
                check("done_after_last", int'(prev_last), int'(exp_last_flag));
                check("done_outputs_left", exp_q.size(), 0);
            end
            prev_last = bus.out_valid && bus.out_last;
        end
    end

    function automatic int outputs_all_zero_vec();
        return int'({bus.in_ready, bus.flt_clr, bus.flt_en, bus.flt_x,
                     bus.out_data, bus.out_valid, bus.out_last, bus.busy, bus.done});
    endfunction

    task automatic run_burst(input vec_t v);
        logic [DW-1:0] samp[$];
        int idx, c, bound, mis;
        int b_out, b_done, b_busy, b_clr, b_stall;
        samp = {};
        for (int i = 0; i < v.len; i++) samp.push_back(v.ramp ? 8'(i + 1) : 8'($urandom));
        // Reference: every real sample doubled, then FLUSH zeros, last on final
        for (int i = 0; i < v.len; i++) exp_q.push_back('{data: 8'(samp[i] * 2), last: 1'b0});
        if (v.len != 0) begin
            for (int i = 0; i < FLUSH; i++) exp_q.push_back('{data: 8'h00, last: (i == FLUSH - 1)});
        end
        exp_last_flag = (v.len != 0);
        en_log.delete();
        first_en_cyc = -1;
        b_out = n_out; b_done = done_cnt; b_busy = busy_cnt; b_clr = clr_cnt; b_stall = stall_cnt;

        @(posedge CLK); #1;
        bus.start = 1'b1; bus.burst_len = 8'(v.len); bus.in_valid = 1'b0;
        idx = 0; c = 0; bound = 40 + 4 * v.len;
        while (done_cnt == b_done && c < bound) begin
            @(posedge CLK); #1;
            bus.start = (v.restart != 0 && c == v.restart);
            if (bus.start) bus.burst_len = 8'd9;
            bus.in_valid = (idx < v.len) && (c >= 32 || v.vpat[c[4:0]]);
            bus.in_data  = bus.in_valid ? samp[idx] : 8'($urandom);
            @(negedge CLK);
            if (bus.in_valid && bus.in_ready) idx++;
            c++;
        end
        @(posedge CLK); #1;
        bus.start = 1'b0; bus.in_valid = 1'b0;
        repeat (3) @(negedge CLK);

        check("done_count", done_cnt - b_done, 1);
        check("out_count", n_out - b_out, v.exp_outs);
        check("clr_count", clr_cnt - b_clr, int'(v.len != 0));
        if (v.len != 0) begin
            mis = 0;
            for (int i = 0; i < en_log.size(); i++) begin
                if (en_log[i] != ((i < v.len) ? samp[i] : 8'h00)) mis++;
            end
            check("en_count", en_log.size(), v.len + FLUSH);
            check("flt_x_seq_mismatches", mis, 0);
            check("clr_before_en", int'(first_en_cyc > clr_cyc), 1);
            if (v.vpat == 32'hFFFF_FFFF) begin
                check("clr_to_first_en", first_en_cyc - clr_cyc, 1);
                check("en_run_length", last_en_cyc - first_en_cyc, v.len + FLUSH - 1);
            end
        end else begin
            check("zero_len_busy_cycles", busy_cnt - b_busy, 1);
        end
        if (v.exp_stall >= 0) check("stall_cycles", stall_cnt - b_stall, v.exp_stall);
    endtask

    task automatic run_abort();
        int idx, c, b_out, b_done, b_busy;
        for (int i = 0; i < 5; i++) exp_q.push_back('{data: 8'((i + 1) * 2), last: 1'b0});
        exp_last_flag = 1;
        @(posedge CLK); #1;
        bus.start = 1'b1; bus.burst_len = 8'd5;
        idx = 0; c = 0;
        while (idx < 2 && c < 50) begin
            @(posedge CLK); #1;
            bus.start    = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(idx + 1);
            @(negedge CLK);
            if (bus.in_valid && bus.in_ready) idx++;
            c++;
        end
        check("abort_samples_accepted", idx, 2);
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        #1 RST = 1'b1;
        #1;
        check("abort_outputs_zero", outputs_all_zero_vec(), 0);
        check("abort_busy", int'(bus.busy), 0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        b_out = n_out; b_done = done_cnt; b_busy = busy_cnt;
        repeat (10) @(negedge CLK);
        check("abort_no_out_valid", n_out - b_out, 0);
        check("abort_no_done", done_cnt - b_done, 0);
        check("abort_idle_busy", busy_cnt - b_busy, 0);
    endtask

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        bus.start = 1'b0; bus.burst_len = '0; bus.in_data = '0; bus.in_valid = 1'b0;

        tbl[0] = '{len: 4,   vpat: 32'hFFFF_FFFF, restart: 0, exp_outs: 4 + FLUSH,   exp_stall: 0,  ramp: 1};
        tbl[1] = '{len: 3,   vpat: 32'hFFFF_FFE7, restart: 0, exp_outs: 3 + FLUSH,   exp_stall: 2,  ramp: 1};
        tbl[2] = '{len: 0,   vpat: 32'hFFFF_FFFF, restart: 0, exp_outs: 0,           exp_stall: 0,  ramp: 0};
        tbl[3] = '{len: 6,   vpat: 32'hFFFF_FFFF, restart: 4, exp_outs: 6 + FLUSH,   exp_stall: 0,  ramp: 0};
        tbl[4] = '{len: 255, vpat: 32'hFFFF_FFFF, restart: 0, exp_outs: 255 + FLUSH, exp_stall: 0,  ramp: 0};
        for (int t = 5; t < 8; t++) begin
            tbl[t].len       = int'($urandom_range(40, 1));
            tbl[t].vpat      = $urandom;
            tbl[t].restart   = 0;
            tbl[t].exp_outs  = tbl[t].len + FLUSH;
            tbl[t].exp_stall = -1;
            tbl[t].ramp      = 0;
        end

        #1;
        check("reset_outputs_zero", outputs_all_zero_vec(), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("post_reset_idle_busy", int'(bus.busy), 0);

        for (int t = 0; t < 8; t++) run_burst(tbl[t]);

        run_abort();
        run_burst('{len: 2, vpat: 32'hFFFF_FFFF, restart: 0, exp_outs: 2 + FLUSH, exp_stall: 0, ramp: 1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
